// File: rtl/stable_match_pkg.sv
// Shared definitions for the stable-matching proposal scheduler:
// width helpers and the scheduler FSM state encoding.
package stable_match_pkg;

    // Ceiling log2 of a positive value (0 for value <= 1)
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Bit width needed to index 'value' items, never narrower than one bit
    function automatic int width_of(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    // Width of an index over S suitors (logS)
    function automatic int log_s(input int s);
        return width_of(s);
    endfunction

    // Width of a preference rank over Ks entries (logKs)
    function automatic int log_ks(input int ks);
        return width_of(ks);
    endfunction

    // Width of a proposal counter holding 0..Ks (PCW)
    function automatic int pc_width(input int ks);
        return width_of(ks + 1);
    endfunction

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/stable_match_sched_rr_pick.sv
// Rotating-priority first-one finder: returns the first set bit of 'elig'
// found when scanning upward from ptr+1 with wrap-around. Purely combinational.
module rr_pick #(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan from farthest to nearest so the candidate closest after ptr is written last
    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr) + k) % N;
            if (elig[j[W-1:0]]) begin
                found = 1'b1;
                idx   = j[W-1:0];
            end else begin
                found = found;
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/stable_match_sched.sv
// Sequential proposal scheduler for the stable-matching engine. Tracks per-suitor
// proposal counters and matched flags, issues one proposal at a time round-robin
// and absorbs the engine's accept/evict result.
// Optional build macro STABLE_MATCH_SCHED_STATS_EN adds proposal/eviction counters.
module stable_match_sched
    import stable_match_pkg::*;
#(
    parameter int S  = 10,
    parameter int R  = 10,
    parameter int Ks = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    prop_valid,
    input  logic                    prop_ready,
    output logic [log_s(S)-1:0]     prop_s,
    output logic [log_ks(Ks)-1:0]   prop_idx,
    input  logic                    res_valid,
    input  logic                    res_accept,
    input  logic                    res_evict_valid,
    input  logic [log_s(S)-1:0]     res_evict_s,
    output logic                    busy,
    output logic                    finish,
    output logic [S-1:0]            sIsMatchWire,
    output logic [S-1:0]            exhausted
`ifdef STABLE_MATCH_SCHED_STATS_EN
    ,
    output logic [width_of(S*Ks+1)-1:0] stat_props,
    output logic [width_of(S*Ks+1)-1:0] stat_evicts
`endif
);

    localparam int LOGS  = log_s(S);
    localparam int LOGKS = log_ks(Ks);
    localparam int PCW   = pc_width(Ks);
    localparam logic [PCW-1:0]  KS_PC    = PCW'(Ks);
    localparam logic [LOGS-1:0] PTR_INIT = LOGS'(S - 1);
`ifdef STABLE_MATCH_SCHED_STATS_EN
    localparam int STW = width_of(S*Ks+1);
`endif

    // The reviewer count only sizes the engine side; both blocks share one parameter set
    if (R < 1) begin : g_no_reviewers
    end

    state_t          state;
    logic [PCW-1:0]  pc [S];
    logic [S-1:0]    matched;
    logic [LOGS-1:0] ptr;
    logic [S-1:0]    elig;
    logic            pick_found;
    logic [LOGS-1:0] pick_idx;
    logic [PCW-1:0]  used_cnt;
    logic            evict_apply;

    assign sIsMatchWire = matched;

    // A suitor may propose while it has proposals left and is not currently matched
    always_comb begin
        elig = '0;
        for (int i = 0; i < S; i++) begin
            elig[i] = (pc[i] != '0) && !matched[i];
        end
    end

    rr_pick #(.N(S), .W(LOGS)) u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Rank of the next proposal equals the number of proposals already spent
    assign used_cnt = KS_PC - pc[pick_idx];

    // Eviction only counts on an accept, for a different, in-range suitor
    assign evict_apply = res_accept && res_evict_valid && (res_evict_s != prop_s) &&
                         (int'(res_evict_s) < S);

    // Scheduler FSM with all outputs and bookkeeping registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            for (int i = 0; i < S; i++) begin
                pc[i] <= KS_PC;
            end
            matched    <= '0;
            ptr        <= PTR_INIT;
            prop_valid <= 1'b0;
            prop_s     <= '0;
            prop_idx   <= '0;
            busy       <= 1'b0;
            finish     <= 1'b0;
            exhausted  <= '0;
`ifdef STABLE_MATCH_SCHED_STATS_EN
            stat_props  <= '0;
            stat_evicts <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int i = 0; i < S; i++) begin
                            pc[i] <= KS_PC;
                        end
                        matched   <= '0;
                        ptr       <= PTR_INIT;
                        finish    <= 1'b0;
                        busy      <= 1'b1;
                        exhausted <= '0;
`ifdef STABLE_MATCH_SCHED_STATS_EN
                        stat_props  <= '0;
                        stat_evicts <= '0;
`endif
                        state     <= SELECT;
                    end else begin
                        state <= state;
                    end
                end
                SELECT: begin
                    if (pick_found) begin
                        prop_s     <= pick_idx;
                        prop_idx   <= used_cnt[LOGKS-1:0];
                        prop_valid <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        finish <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                ISSUE: begin
                    if (prop_ready) begin
                        pc[prop_s]        <= pc[prop_s] - PCW'(1);
                        exhausted[prop_s] <= (pc[prop_s] == PCW'(1));
                        ptr               <= prop_s;
                        prop_valid        <= 1'b0;
`ifdef STABLE_MATCH_SCHED_STATS_EN
                        if (stat_props != '1) begin
                            stat_props <= stat_props + STW'(1);
                        end
`endif
                        state             <= WAIT;
                    end else begin
                        state <= ISSUE;
                    end
                end
                WAIT: begin
                    if (res_valid) begin
                        if (res_accept) begin
                            matched[prop_s] <= 1'b1;
                        end
                        if (evict_apply) begin
                            matched[res_evict_s] <= 1'b0;
`ifdef STABLE_MATCH_SCHED_STATS_EN
                            if (stat_evicts != '1) begin
                                stat_evicts <= stat_evicts + STW'(1);
                            end
`endif
                        end
                        state <= SELECT;
                    end else begin
                        state <= WAIT;
                    end
                end
                default: begin
                    prop_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stable_match_sched.sv
// Self-checking bench for stable_match_sched with S=R=Ks=4. A rule-level model
// (counters, flags and a rotating search) predicts every proposal.
module tb_stable_match_sched;

    localparam int S  = 4;
    localparam int KS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       prop_ready = 1'b0;
    logic       res_valid = 1'b0;
    logic       res_accept = 1'b0;
    logic       res_evict_valid = 1'b0;
    logic [1:0] res_evict_s = 2'd0;
    logic       prop_valid;
    logic [1:0] prop_s;
    logic [1:0] prop_idx;
    logic       busy;
    logic       finish;
    logic [3:0] match_v;
    logic [3:0] exh;
`ifdef STABLE_MATCH_SCHED_STATS_EN
    logic [4:0] stat_props;
    logic [4:0] stat_evicts;
`endif

    always #5 clk = ~clk;

    stable_match_sched #(.S(4), .R(4), .Ks(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .prop_valid      (prop_valid),
        .prop_ready      (prop_ready),
        .prop_s          (prop_s),
        .prop_idx        (prop_idx),
        .res_valid       (res_valid),
        .res_accept      (res_accept),
        .res_evict_valid (res_evict_valid),
        .res_evict_s     (res_evict_s),
        .busy            (busy),
        .finish          (finish),
        .sIsMatchWire    (match_v),
        .exhausted       (exh)
`ifdef STABLE_MATCH_SCHED_STATS_EN
        ,
        .stat_props      (stat_props),
        .stat_evicts     (stat_evicts)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int pc_m [4];
    bit m_m [4];
    int ptr_m;

    function automatic void model_start();
        for (int i = 0; i < S; i++) begin
            pc_m[i] = KS;
            m_m[i]  = 1'b0;
        end
        ptr_m = S - 1;
    endfunction

    function automatic int model_pick();
        for (int k = 1; k <= S; k++) begin
            int i;
            i = (ptr_m + k) % S;
            if (pc_m[i] != 0 && !m_m[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_handshake(input int s);
        pc_m[s] = pc_m[s] - 1;
        ptr_m   = s;
    endfunction

    function automatic void model_result(input int s, input bit acc, input bit evv, input int evs);
        if (acc) begin
            m_m[s] = 1'b1;
            if (evv && evs != s && evs < S) m_m[evs] = 1'b0;
        end
    endfunction

    function automatic logic [3:0] model_matched();
        logic [3:0] v;
        for (int i = 0; i < S; i++) v[i] = m_m[i];
        return v;
    endfunction

    function automatic logic [3:0] model_exh();
        logic [3:0] v;
        for (int i = 0; i < S; i++) v[i] = (pc_m[i] == 0);
        return v;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        model_start();
    endtask

    // Waits for an offer, handshakes it, then returns the given result
    task automatic exchange(input bit acc, input bit evv, input logic [1:0] evs,
                            input int hold, input int res_delay,
                            output int got_s, output int got_idx, output int lat, output bit ok);
        ok = 1'b0; lat = 0; got_s = -1; got_idx = -1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            lat++;
            if (prop_valid === 1'b1) ok = 1'b1;
        end
        if (!ok) return;
        got_s = int'(prop_s);
        got_idx = int'(prop_idx);
        repeat (hold) @(negedge clk);
        prop_ready = 1'b1;
        @(posedge clk); #1 prop_ready = 1'b0;
        for (int i = 0; i < res_delay; i++) begin
            @(posedge clk); #1;
        end
        res_valid = 1'b1; res_accept = acc; res_evict_valid = evv; res_evict_s = evs;
        @(posedge clk); #1;
        res_valid = 1'b0; res_accept = 1'b0; res_evict_valid = 1'b0; res_evict_s = 2'd0;
    endtask

    task automatic test_reset();
        bit seen;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({prop_valid, busy, finish} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ctrl got=%b want=000", {prop_valid, busy, finish});
        end
        n_cmp++;
        if ({match_v, exh} !== 8'h00) begin
            n_bad++; $display("FAIL reset_flags got=%h want=00", {match_v, exh});
        end
        @(negedge clk) rst = 1'b1;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (prop_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL reset_first_offer got=timeout want=prop_valid");
        end
        prop_ready = 1'b1;
        @(posedge clk); #1 prop_ready = 1'b0;
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if ({prop_valid, busy, finish, match_v, exh} !== 11'd0) begin
            n_bad++; $display("FAIL reset_async got=%b want=0", {prop_valid, busy, finish, match_v, exh});
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1 res_valid = 1'b1; res_accept = 1'b1;
        @(posedge clk); #1 res_valid = 1'b0; res_accept = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({prop_valid, busy, match_v} !== 6'd0) begin
                n_bad++; $display("FAIL reset_res_ignored got=%b want=0", {prop_valid, busy, match_v});
            end
        end
    endtask

    task automatic test_all_accept();
        int gs, gi, lat, exp_s;
        bit ok;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            exp_s = model_pick();
            exchange(1'b1, 1'b0, 2'd0, 0, 0, gs, gi, lat, ok);
            n_cmp++;
            if (!ok || gs != k || gs != exp_s || gi != 0 || lat != 2) begin
                n_bad++;
                $display("FAIL accept_issue k=%0d got s=%0d idx=%0d lat=%0d ok=%0d want s=%0d idx=0 lat=2",
                         k, gs, gi, lat, ok, k);
            end
            model_handshake(exp_s);
            model_result(exp_s, 1'b1, 1'b0, 0);
        end
        @(negedge clk);
        n_cmp++;
        if (finish !== 1'b0) begin
            n_bad++; $display("FAIL accept_finish_early got=%b want=0", finish);
        end
        @(negedge clk);
        n_cmp++;
        if ({finish, busy, match_v, exh} !== {1'b1, 1'b0, 4'b1111, 4'b0000}) begin
            n_bad++; $display("FAIL accept_done got=%b want=10_1111_0000", {finish, busy, match_v, exh});
        end
    endtask

    task automatic test_backpressure();
        int gs, gi, lat, exp_s;
        bit ok, seen;
        logic [1:0] s0, i0;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (prop_valid === 1'b1) seen = 1'b1;
        end
        s0 = prop_s; i0 = prop_idx;
        n_cmp++;
        if (!seen || s0 !== 2'd0 || i0 !== 2'd0) begin
            n_bad++; $display("FAIL bp_first got s=%0d idx=%0d seen=%0d want s=0 idx=0", s0, i0, seen);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (prop_valid !== 1'b1 || prop_s !== s0 || prop_idx !== i0 || exh !== 4'b0000) begin
                n_bad++; $display("FAIL bp_hold cyc=%0d got v=%b s=%0d idx=%0d want v=1 s=%0d idx=%0d",
                                  i, prop_valid, prop_s, prop_idx, s0, i0);
            end
        end
        prop_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 prop_ready = 1'b0;
        model_handshake(0);
        res_valid = 1'b1; res_accept = 1'b0;
        @(posedge clk); #1 res_valid = 1'b0;
        model_result(0, 1'b0, 1'b0, 0);
        while (model_pick() != -1) begin
            exp_s = model_pick();
            exchange(1'b1, 1'b0, 2'd0, 0, 0, gs, gi, lat, ok);
            n_cmp++;
            if (!ok || gs != exp_s || gi != KS - pc_m[exp_s]) begin
                n_bad++; $display("FAIL bp_issue got s=%0d idx=%0d want s=%0d idx=%0d",
                                  gs, gi, exp_s, KS - pc_m[exp_s]);
            end
            model_handshake(exp_s);
            model_result(exp_s, 1'b1, 1'b0, 0);
            if (!ok) break;
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (finish !== 1'b1 || match_v !== 4'b1111) begin
            n_bad++; $display("FAIL bp_done got fin=%b m=%b want fin=1 m=1111", finish, match_v);
        end
    endtask

    task automatic test_evict();
        int gs, gi, lat;
        bit ok;
        int exp_s [5] = '{0, 1, 2, 3, 0};
        int exp_i [5] = '{0, 0, 0, 0, 1};
        bit evv_t [5] = '{0, 1, 0, 0, 0};
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            exchange(1'b1, evv_t[k], 2'd0, 0, 1, gs, gi, lat, ok);
            n_cmp++;
            if (!ok || gs != exp_s[k] || gs != model_pick() || gi != exp_i[k]) begin
                n_bad++; $display("FAIL evict_issue k=%0d got s=%0d idx=%0d want s=%0d idx=%0d",
                                  k, gs, gi, exp_s[k], exp_i[k]);
            end
            model_handshake(exp_s[k]);
            model_result(exp_s[k], 1'b1, evv_t[k], 0);
            if (k == 1) begin
                n_cmp++;
                if (match_v !== 4'b0010 || match_v !== model_matched()) begin
                    n_bad++; $display("FAIL evict_flags got=%b want=0010", match_v);
                end
            end
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (finish !== 1'b1 || match_v !== 4'b1111) begin
            n_bad++; $display("FAIL evict_done got fin=%b m=%b want fin=1 m=1111", finish, match_v);
        end
`ifdef STABLE_MATCH_SCHED_STATS_EN
        n_cmp++;
        if (stat_props !== 5'd5 || stat_evicts !== 5'd1) begin
            n_bad++; $display("FAIL evict_stats got props=%0d evicts=%0d want props=5 evicts=1",
                              stat_props, stat_evicts);
        end
`endif
    endtask

    task automatic test_all_reject();
        int gs, gi, lat, exp_s;
        bit ok;
        for (int run = 0; run < 2; run++) begin
            pulse_start();
            for (int k = 0; k < 16; k++) begin
                exp_s = model_pick();
                exchange(1'b0, 1'b1, 2'(k + 1), 0, 0, gs, gi, lat, ok);
                n_cmp++;
                if (!ok || gs != k % 4 || gs != exp_s || gi != k / 4) begin
                    n_bad++; $display("FAIL reject_issue run=%0d k=%0d got s=%0d idx=%0d want s=%0d idx=%0d",
                                      run, k, gs, gi, k % 4, k / 4);
                end
                model_handshake(exp_s);
                model_result(exp_s, 1'b0, 1'b1, (k + 1) % 4);
            end
            repeat (2) @(negedge clk);
            n_cmp++;
            if ({finish, exh, match_v} !== {1'b1, 4'b1111, 4'b0000} || model_pick() != -1) begin
                n_bad++; $display("FAIL reject_done run=%0d got=%b want=1_1111_0000", run, {finish, exh, match_v});
            end
        end
    endtask

    task automatic test_ignored_inputs();
        int gs, gi, lat, exp_s;
        bit ok, seen;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (prop_valid === 1'b1) seen = 1'b1;
        end
        prop_ready = 1'b1;
        @(posedge clk); #1 prop_ready = 1'b0;
        model_handshake(0);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        res_valid = 1'b1; res_accept = 1'b1;
        @(posedge clk); #1;
        model_result(0, 1'b1, 1'b0, 0);
        res_valid = 1'b1; res_accept = 1'b1; res_evict_valid = 1'b1; res_evict_s = 2'd1;
        @(posedge clk); #1;
        res_valid = 1'b0; res_accept = 1'b0; res_evict_valid = 1'b0; res_evict_s = 2'd0;
        n_cmp++;
        if (!seen || busy !== 1'b1 || match_v !== 4'b0001) begin
            n_bad++; $display("FAIL ignore_state got seen=%0d busy=%b m=%b want busy=1 m=0001", seen, busy, match_v);
        end
        for (int k = 1; k < 4; k++) begin
            exp_s = model_pick();
            exchange(1'b1, 1'b0, 2'd0, 0, 0, gs, gi, lat, ok);
            n_cmp++;
            if (!ok || gs != k || gs != exp_s || gi != 0) begin
                n_bad++; $display("FAIL ignore_issue got s=%0d idx=%0d want s=%0d idx=0", gs, gi, k);
            end
            model_handshake(exp_s);
            model_result(exp_s, 1'b1, 1'b0, 0);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (finish !== 1'b1 || match_v !== 4'b1111) begin
            n_bad++; $display("FAIL ignore_done got fin=%b m=%b want fin=1 m=1111", finish, match_v);
        end
    endtask

    task automatic test_random();
        int gs, gi, lat, exp_s, evs;
        bit ok, acc, evv;
        for (int run = 0; run < 4; run++) begin
            pulse_start();
            while (model_pick() != -1) begin
                exp_s = model_pick();
                acc = 1'($urandom_range(0, 1));
                evv = 1'($urandom_range(0, 1));
                evs = int'($urandom_range(0, 3));
                exchange(acc, evv, 2'(evs), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                         gs, gi, lat, ok);
                model_handshake(exp_s);
                model_result(exp_s, acc, evv, evs);
                n_cmp++;
                if (!ok || gs != exp_s || gi != KS - 1 - pc_m[exp_s] ||
                    match_v !== model_matched() || exh !== model_exh()) begin
                    n_bad++;
                    $display("FAIL random_step run=%0d got s=%0d idx=%0d m=%b x=%b want s=%0d idx=%0d m=%b x=%b",
                             run, gs, gi, match_v, exh, exp_s, KS - 1 - pc_m[exp_s],
                             model_matched(), model_exh());
                end
                if (!ok) break;
            end
            repeat (2) @(negedge clk);
            n_cmp++;
            if (finish !== 1'b1 || busy !== 1'b0) begin
                n_bad++; $display("FAIL random_done run=%0d got fin=%b busy=%b want fin=1 busy=0", run, finish, busy);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_all_accept();
        test_backpressure();
        test_evict();
        test_all_reject();
        test_ignored_inputs();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
